// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweep controller.
package tt_sweep_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam int SETTLE_W = 8;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// Host/gate-side bundle of the sweep controller; slave is the controller, master is the host plus gate.
interface tt_sweep_ctrl_if import tt_sweep_pkg::*; #(
  parameter int N_IN = 4
) ();
  localparam int TT_W = tt_width(N_IN);

  logic            start;
  logic            abort;
  logic [TT_W-1:0] expected;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [TT_W-1:0] tt_result;
  logic            mismatch;
  logic [N_IN-1:0] first_fail;

  modport master (
    output start, abort, expected, dut_out,
    input  dut_in, busy, done, pass, tt_result, mismatch, first_fail
  );

  modport slave (
    input  start, abort, expected, dut_out,
    output dut_in, busy, done, pass, tt_result, mismatch, first_fail
  );

endinterface

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that measures how long each vector settles before sampling.
module tt_settle_timer import tt_sweep_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps every input vector of a combinational gate, builds its truth table and compares it to an expected one.
//   state  | meaning
//   IDLE   | waiting for start; results of the last sweep held
//   SETTLE | current vector driven, waiting for the timer to expire
//   SAMPLE | capture gate output, advance to the next vector or finish
//   DONE   | one-cycle done pulse with pass verdict
module tt_sweep_ctrl import tt_sweep_pkg::*; #(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input logic            clk,
  input logic            rst,
  tt_sweep_ctrl_if.slave bus
);

  localparam int              TT_W   = tt_width(N_IN);
  localparam logic [N_IN-1:0] K_LAST = '1;

  state_t          state;
  logic [N_IN-1:0] k;
  logic [TT_W-1:0] exp_q;
  logic [TT_W-1:0] tt_q;
  logic [TT_W-1:0] tt_next;
  logic [N_IN-1:0] ff_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic            mism_q;
  logic            exp_bit;
  logic            tmr_load;
  logic            tmr_zero;

  assign tt_next  = {tt_q[TT_W-2:0], bus.dut_out};
  // Vector k lives at bit TT_W-1-k, which is simply ~k for an N_IN-bit index.
  assign exp_bit  = exp_q[~k];
  assign tmr_load = (state == IDLE && bus.start) ||
                    (state == SAMPLE && !bus.abort && k != K_LAST);

  tt_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_W'(SETTLE_CYCLES)),
    .dec      (state == SETTLE),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      exp_q  <= '0;
      tt_q   <= '0;
      ff_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      mism_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            exp_q  <= bus.expected;
            tt_q   <= '0;
            ff_q   <= '0;
            mism_q <= 1'b0;
            pass_q <= 1'b0;
            busy_q <= 1'b1;
            k      <= '0;
            state  <= SETTLE;
          end
        end
        SETTLE, SAMPLE: begin
          // Abort keeps the partial table and mismatch info for inspection.
          if (bus.abort) begin
            busy_q <= 1'b0;
            pass_q <= 1'b0;
            k      <= '0;
            state  <= IDLE;
          end else if (state == SETTLE) begin
            if (tmr_zero) state <= SAMPLE;
          end else begin
            tt_q <= tt_next;
            if (bus.dut_out != exp_bit && !mism_q) begin
              mism_q <= 1'b1;
              ff_q   <= k;
            end
            if (k == K_LAST) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              pass_q <= (tt_next == exp_q);
              state  <= DONE;
            end else begin
              k     <= k + 1'b1;
              state <= SETTLE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dut_in     = k;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.tt_result  = tt_q;
  assign bus.mismatch   = mism_q;
  assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench: two controllers (settle 2 and settle 0) sweep the same gate models side by side.
module tb_tt_sweep_ctrl;
  import tt_sweep_pkg::*;

  localparam int N_IN = 4;
  localparam int TT_W = 16;

  typedef struct {
    logic [15:0] tt;
    logic        pass;
    logic        mism;
    logic [3:0]  ff;
    int          done_cyc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  int          mode;
  logic [15:0] lut;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  sb_t         q2[$];
  sb_t         q0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic gate(input logic [3:0] v, input int m, input logic [15:0] l);
    logic a, b, c, d;
    {a, b, c, d} = v;
    if (m == 0) return ~((a & ~b) | (~a & c & d) | (b & ~d & (a | ~c)));
    else if (m == 1) return 1'b1;
    else return l[v];
  endfunction

  tt_sweep_ctrl_if #(.N_IN(N_IN)) bus2 ();
  tt_sweep_ctrl_if #(.N_IN(N_IN)) bus0 ();

  assign bus2.start    = start;
  assign bus2.abort    = abort;
  assign bus2.expected = expected;
  assign bus2.dut_out  = gate(bus2.dut_in, mode, lut);
  assign bus0.start    = start;
  assign bus0.abort    = abort;
  assign bus0.expected = expected;
  assign bus0.dut_out  = gate(bus0.dut_in, mode, lut);

  tt_sweep_ctrl #(.N_IN(N_IN), .SETTLE_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  tt_sweep_ctrl #(.N_IN(N_IN), .SETTLE_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: sample for vector k goes to bit TT_W-1-k; first differing k is reported.
  function automatic sb_t model(input logic [15:0] ex);
    sb_t  e;
    logic s;
    e.tt = '0; e.mism = 1'b0; e.ff = '0; e.done_cyc = 0;
    for (int k = 0; k < TT_W; k++) begin
      s = gate(4'(k), mode, lut);
      e.tt[TT_W-1-k] = s;
      if (s != ex[TT_W-1-k] && !e.mism) begin
        e.mism = 1'b1;
        e.ff   = 4'(k);
      end
    end
    e.pass = (e.tt == ex);
    return e;
  endfunction

  task automatic sb_cmp(input string tag, input sb_t e, input logic [15:0] tt, input logic p,
                        input logic m, input logic [3:0] ff, input logic b);
    chk({tag, " done cycle"}, cyc, e.done_cyc);
    chk({tag, " tt_result"}, tt, e.tt);
    chk({tag, " pass"}, p, e.pass);
    chk({tag, " mismatch"}, m, e.mism);
    chk({tag, " first_fail"}, ff, e.ff);
    chk({tag, " busy at done"}, b, 1'b0);
  endtask

  task automatic chk_zero(input string tag, input logic [3:0] di, input logic b, input logic d,
                          input logic p, input logic m, input logic [15:0] tt, input logic [3:0] ff);
    chk({tag, " dut_in"}, di, 4'h0);
    chk({tag, " busy"}, b, 1'b0);
    chk({tag, " done"}, d, 1'b0);
    chk({tag, " pass"}, p, 1'b0);
    chk({tag, " mismatch"}, m, 1'b0);
    chk({tag, " tt_result"}, tt, 16'h0);
    chk({tag, " first_fail"}, ff, 4'h0);
  endtask

  always @(negedge clk) begin
    if (bus2.done) begin
      if (q2.size() == 0) begin
        tests++; fails++;
        $display("FAIL s2 unexpected done: got 1 expected 0");
      end else begin
        sb_cmp("s2", q2.pop_front(), bus2.tt_result, bus2.pass, bus2.mismatch, bus2.first_fail, bus2.busy);
      end
    end
  end

  always @(negedge clk) begin
    if (bus0.done) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL s0 unexpected done: got 1 expected 0");
      end else begin
        sb_cmp("s0", q0.pop_front(), bus0.tt_result, bus0.pass, bus0.mismatch, bus0.first_fail, bus0.busy);
      end
    end
  end

  // With zero settle, each vector must be held exactly two cycles and step by one.
  int         run0 = 0;
  logic [3:0] prev0 = '0;
  always @(negedge clk) begin
    if (!bus0.busy) begin
      run0  = 0;
      prev0 = '0;
    end else if (run0 == 0 || bus0.dut_in == prev0) begin
      run0++;
    end else begin
      chk("s0 step hold", run0, 2);
      chk("s0 step inc", bus0.dut_in, 4'(prev0 + 1'b1));
      prev0 = bus0.dut_in;
      run0  = 1;
    end
  end

  task automatic start_sweep(input logic [15:0] ex);
    sb_t e;
    @(posedge clk); #1;
    start    = 1'b1;
    expected = ex;
    e = model(ex);
    e.done_cyc = cyc + TT_W * (2 + 2) + 1;
    q2.push_back(e);
    e.done_cyc = cyc + TT_W * (0 + 2) + 1;
    q0.push_back(e);
    @(posedge clk); #1;
    start    = 1'b0;
    expected = 16'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q2.size() == 0 && q0.size() == 0) return;
    end
    tests++; fails++;
    $display("FAIL sweep timeout: got %0d pending expected 0", q2.size() + q0.size());
    q2.delete();
    q0.delete();
  endtask

  task automatic wait_vec(input logic [3:0] v, output logic found);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus2.busy && bus2.dut_in == v) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic        found;
    logic [15:0] ref_tt;
    logic [15:0] mask;

    rst = 1'b1; start = 1'b0; abort = 1'b0; expected = '0; mode = 0; lut = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset s2", bus2.dut_in, bus2.busy, bus2.done, bus2.pass, bus2.mismatch, bus2.tt_result, bus2.first_fail);
    chk_zero("reset s0", bus0.dut_in, bus0.busy, bus0.done, bus0.pass, bus0.mismatch, bus0.tt_result, bus0.first_fail);
    @(negedge clk) rst = 1'b0;

    // Reference gate, matching expectation.
    mode = 0;
    start_sweep(16'hE605);
    wait_done();
    chk("sc1 tt const", bus2.tt_result, 16'hE605);
    chk("sc4 tt const", bus0.tt_result, 16'hE605);
    chk("sc1 pass held", bus2.pass, 1'b1);

    // One bit off at vector 15.
    start_sweep(16'hE604);
    wait_done();
    chk("sc2 first_fail const", bus2.first_fail, 4'd15);
    chk("sc2 mismatch const", bus2.mismatch, 1'b1);

    // Output tied high, expectation wrong at vector 0.
    mode = 1;
    start_sweep(16'h7FFF);
    wait_done();
    chk("sc3 tt const", bus2.tt_result, 16'hFFFF);
    chk("sc3 first_fail const", bus2.first_fail, 4'd0);

    // Abort partway through.
    mode = 0;
    start_sweep(16'hE605);
    wait_vec(4'd6, found);
    chk("abort reached vec6", found, 1'b1);
    q2.delete();
    q0.delete();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort s2 busy", bus2.busy, 1'b0);
    chk("abort s2 dut_in", bus2.dut_in, 4'h0);
    chk("abort s2 pass", bus2.pass, 1'b0);
    chk("abort s0 busy", bus0.busy, 1'b0);
    chk("abort s0 dut_in", bus0.dut_in, 4'h0);
    repeat (80) @(negedge clk);
    chk("abort s2 stays idle", bus2.busy, 1'b0);
    start_sweep(16'hE605);
    wait_done();
    chk("after abort pass", bus2.pass, 1'b1);

    // Extra start while busy must be ignored.
    start_sweep(16'hE605);
    repeat (20) @(posedge clk);
    #1;
    start = 1'b1; expected = 16'h0000;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // Random gates against random expectations.
    mode = 2;
    for (int i = 0; i < 8; i++) begin
      lut    = 16'($urandom);
      ref_tt = model(16'h0).tt;
      mask   = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0;
      start_sweep(ref_tt ^ mask);
      wait_done();
    end

    // Reset during vector 9.
    lut = 16'($urandom);
    start_sweep(16'($urandom));
    wait_vec(4'd9, found);
    chk("reset reached vec9", found, 1'b1);
    rst = 1'b1;
    #1;
    q2.delete();
    q0.delete();
    chk_zero("midrst s2", bus2.dut_in, bus2.busy, bus2.done, bus2.pass, bus2.mismatch, bus2.tt_result, bus2.first_fail);
    chk_zero("midrst s0", bus0.dut_in, bus0.busy, bus0.done, bus0.pass, bus0.mismatch, bus0.tt_result, bus0.first_fail);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (80) @(negedge clk);

    mode = 0;
    start_sweep(16'hE605);
    wait_done();
    chk("post reset pass", bus2.pass, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
